// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the pipeline stage register.
//   ALU_ADD       : ALU opcode carried by a bubble (no-op add).
//   CTRL_RST_DEF  : default bubble/reset control word (ALU field in [4:0]).
//   stage_state_t : occupancy of the stage (EMPTY, FULL, SKID).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [4:0]  ALU_ADD      = 5'b00010;
    localparam int          CTRL_W_DEF   = 16;
    localparam logic [15:0] CTRL_RST_DEF = 16'(ALU_ADD);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage entry of the stage: a valid flag plus control and data payload.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_load         : capture i_ctrl/i_data and mark the entry valid
//   i_clear        : invalidate the entry (wins over i_load); data is kept
//   i_ctrl, i_data : payload to capture
//   o_valid        : entry holds a beat
//   o_ctrl         : held control word, or CTRL_RST while invalid
//   o_data         : held data word (last captured value while invalid)
// ---------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    // NOTE: the data word is reset too, because the stage must present zero
    // data while in reset; it is a plain register, not a RAM.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RST;
            data_q  <= '0;
        end else if (i_clear) begin
            valid_q <= 1'b0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            ctrl_q  <= i_ctrl;
            data_q  <= i_data;
        end
    end

    // An empty entry must look like a bubble downstream.
    assign o_valid = valid_q;
    assign o_ctrl  = valid_q ? ctrl_q : CTRL_RST;
    assign o_data  = data_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register with flush and stall, one cycle latency.
// Optional skid entry enabled by defining the macro PIPE_STAGE_SKID_EN; it
// decouples o_in_ready from i_out_ready. Default build: single entry.
// Ports:
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   i_flush                   : synchronous kill of all held beats
//   i_stall                   : block acceptance (does not block drain)
//   i_in_valid / o_in_ready   : upstream handshake
//   i_in_ctrl, i_in_data      : upstream payload
//   o_out_valid / i_out_ready : downstream handshake
//   o_out_ctrl, o_out_data    : registered payload (ctrl = CTRL_RST if empty)
//   o_count                   : number of held beats
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_count
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    logic              in_fire;
    logic              out_fire;
    stage_state_t      state;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_main (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (main_load),
        .i_clear (main_clear),
        .i_ctrl  (main_ctrl_in),
        .i_data  (main_data_in),
        .o_valid (main_valid),
        .o_ctrl  (main_ctrl),
        .o_data  (main_data)
    );

    assign out_fire = main_valid && i_out_ready;
    assign in_fire  = i_in_valid && o_in_ready;

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_clear;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (skid_load),
        .i_clear (skid_clear),
        .i_ctrl  (i_in_ctrl),
        .i_data  (i_in_data),
        .o_valid (skid_valid),
        .o_ctrl  (skid_ctrl),
        .o_data  (skid_data)
    );

    // Ready depends only on the registered skid flag, never on i_out_ready.
    assign o_in_ready = !i_stall && !i_flush && !skid_valid;
    assign state      = skid_valid ? SKID : (main_valid ? FULL : EMPTY);
    assign o_count    = {1'b0, main_valid} + {1'b0, skid_valid};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        main_ctrl_in = i_in_ctrl;
        main_data_in = i_in_data;
        if (i_flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: main_load = in_fire;
                FULL: begin
                    if (out_fire) begin
                        // Head leaves; a new beat (if any) takes its place.
                        main_load  = in_fire;
                        main_clear = !in_fire;
                    end else begin
                        // Head is stuck; park the incoming beat behind it.
                        skid_load = in_fire;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_load    = 1'b1;
                        main_ctrl_in = skid_ctrl;
                        main_data_in = skid_data;
                        skid_clear   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`else

    // Can accept when empty, or when the held beat leaves this same cycle.
    assign o_in_ready = !i_stall && !i_flush && (!main_valid || i_out_ready);
    assign state      = main_valid ? FULL : EMPTY;
    assign o_count    = {1'b0, main_valid};

    always_comb begin
        main_load    = 1'b0;
        main_clear   = 1'b0;
        main_ctrl_in = i_in_ctrl;
        main_data_in = i_in_data;
        if (i_flush) begin
            main_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: main_load = in_fire;
                FULL: begin
                    // Simultaneous in+out replaces the entry and stays FULL.
                    main_load  = in_fire;
                    main_clear = out_fire && !in_fire;
                end
                default: ;
            endcase
        end
    end

`endif

    assign o_out_valid = main_valid;
    assign o_out_ctrl  = main_ctrl;
    assign o_out_data  = main_data;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. The reference model is a queue of
// held beats with capacity 1 (default) or 2 (PIPE_STAGE_SKID_EN defined).
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 16;
    localparam logic [CTRL_W-1:0] EXP_CTRL_RST = 16'h0002;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_flush;
    logic              i_stall;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [CTRL_W-1:0] i_in_ctrl;
    logic [DATA_W-1:0] i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [CTRL_W-1:0] o_out_ctrl;
    logic [DATA_W-1:0] o_out_data;
    logic [1:0]        o_count;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_stall     (i_stall),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_ctrl   (i_in_ctrl),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_ctrl  (o_out_ctrl),
        .o_out_data  (o_out_data),
        .o_count     (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             q[$];
    logic [DATA_W-1:0] last_data;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready();
        if (i_stall || i_flush) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || i_out_ready;
    endfunction

    task automatic check_outputs();
        logic              v;
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
        v = q.size() > 0;
        c = v ? q[0].ctrl : EXP_CTRL_RST;
        d = v ? q[0].data : last_data;
        chk("out_valid", DATA_W'(o_out_valid), DATA_W'(v));
        chk("out_ctrl",  DATA_W'(o_out_ctrl),  DATA_W'(c));
        chk("out_data",  o_out_data,           d);
        chk("count",     DATA_W'(o_count),     DATA_W'(q.size()));
        chk("in_ready",  DATA_W'(o_in_ready),  DATA_W'(exp_ready()));
    endtask

    // Apply one cycle of inputs, check, clock, then advance the model.
    task automatic cycle(input logic v, input logic st, input logic fl,
                         input logic rdy, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d);
        logic  in_fire;
        logic  out_fire;
        beat_t b;
        i_in_valid  = v;
        i_stall     = st;
        i_flush     = fl;
        i_out_ready = rdy;
        i_in_ctrl   = c;
        i_in_data   = d;
        #1;
        check_outputs();
        in_fire  = v && exp_ready();
        out_fire = (q.size() > 0) && rdy;
        b.ctrl   = c;
        b.data   = d;
        @(posedge i_clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire)  q.push_back(b);
        end
        if (q.size() > 0) last_data = q[0].data;
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        i_reset     = 1'b1;
        i_flush     = 1'b0;
        i_stall     = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        i_in_ctrl   = '0;
        i_in_data   = '0;
        last_data   = '0;
        #2;
        // Reset state
        check_outputs();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Streaming 1..8 with ready always high
        for (int k = 1; k <= 8; k++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'(k + 16'h100), DATA_W'(k));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Backpressure: downstream blocked for 3 cycles with input valid
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h00b0 + 16'(k), DATA_W'(16'hb0 + k));
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Flush with a valid beat 0xA5 on the input
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0c01, DATA_W'(16'h0c01));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h00a5, DATA_W'(8'ha5));
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Stall while FULL with ready high: drains and leaves a bubble
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0d01, DATA_W'(16'h0d01));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0d02, DATA_W'(16'h0d02));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0d03, DATA_W'(16'h0d03));

        // Reset mid-stream with beats held, checked without a clock edge
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0e01, DATA_W'(16'h0e01));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0e02, DATA_W'(16'h0e02));
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        i_reset     = 1'b1;
        #1;
        chk("rst_valid", DATA_W'(o_out_valid), '0);
        chk("rst_ctrl",  DATA_W'(o_out_ctrl),  DATA_W'(EXP_CTRL_RST));
        chk("rst_count", DATA_W'(o_count),     '0);
        chk("rst_data",  o_out_data,           '0);
        q.delete();
        last_data = '0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        // First beat after reset accepted on the first edge
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0f01, DATA_W'(16'h0f01));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        // Random traffic
        for (int n = 0; n < 10000; n++)
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 60,
                  16'($urandom()), rnd_data());
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128; data payload width in bits (e.g. pc, regdata1, regdata2, imm, p4 concatenated).
REQ-002 Parameter CTRL_W, default 16; control payload width in bits.
REQ-003 Parameter CTRL_RST, default {CTRL_W{1'b0}} with ALU field = 5'b00010; bubble/reset value of the control payload.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_flush  in  1  synchronous kill of all held entries.
REQ-007 i_stall  in  1  blocks acceptance of new input.
REQ-008 i_in_valid  in  1  upstream beat valid.
REQ-009 o_in_ready  out  1  stage can accept a beat.
REQ-010 i_in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 i_in_data  in  DATA_W  upstream data payload.
REQ-012 o_out_valid  out  1  downstream beat valid.
REQ-013 i_out_ready  in  1  downstream accepts beat.
REQ-014 o_out_ctrl  out  CTRL_W  registered control payload.
REQ-015 o_out_data  out  DATA_W  registered data payload.
REQ-016 o_count  out  2  held entries (0..1 without skid, 0..2 with skid).

Function
REQ-017 Input transfer SHALL occur when i_in_valid && o_in_ready; output transfer when o_out_valid && i_out_ready.
REQ-018 Latency SHALL be 1 cycle: a beat accepted into an empty stage appears on outputs the next cycle.
REQ-019 o_in_ready SHALL be 0 whenever i_stall or i_flush is 1.
REQ-020 i_stall SHALL NOT block output drain; a held beat may transfer out during stall, leaving a bubble.
REQ-021 While o_out_valid=0, o_out_ctrl SHALL equal CTRL_RST; o_out_data holds its last value.
REQ-022 i_flush=1 SHALL make next cycle o_out_valid=0, o_count=0, o_out_ctrl=CTRL_RST, regardless of simultaneous input or output handshakes.
REQ-023 Without skid: states EMPTY, FULL; o_in_ready = !i_stall && !i_flush && (!o_out_valid || i_out_ready); simultaneous in+out transfer in FULL SHALL replace the entry and stay FULL.
REQ-024 Beat order SHALL be preserved; no beat duplicated or dropped except by i_flush.
REQ-025 A held beat SHALL remain stable on outputs while o_out_valid && !i_out_ready.

Reset
REQ-026 On i_reset=1, immediately and independent of i_clk: o_out_valid=0, o_count=0, o_out_ctrl=CTRL_RST, o_out_data=0, all internal entries invalid.
REQ-027 Reset asserted mid-transfer SHALL discard all held beats; first beat after deassertion is accepted on the first rising edge with o_in_ready=1.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL, when defined, add a second (skid) entry; states EMPTY, FULL, SKID.
REQ-029 With PIPE_STAGE_SKID_EN: o_in_ready SHALL be registered-derived (!skid_valid) gated only by i_stall/i_flush, with no combinational path from i_out_ready.
REQ-030 With PIPE_STAGE_SKID_EN: beat accepted while FULL and !i_out_ready SHALL enter skid (state SKID, o_count=2); on next output transfer skid moves to main (state FULL).
REQ-031 Without PIPE_STAGE_SKID_EN, behaviour SHALL be exactly REQ-023, with no skid storage synthesised.

Structure
REQ-032 Package pipe_pkg SHALL hold ALU_ADD = 5'b00010, the default CTRL_RST constant, and the stage state enum (EMPTY, FULL, SKID).
REQ-033 Sub-module pipe_slot SHALL implement one entry (valid, ctrl, data; load, clear); instantiated once, twice with PIPE_STAGE_SKID_EN.

Verification
REQ-034 Reset: assert i_reset mid-stream with 2 beats held -> o_out_valid=0, o_out_ctrl=CTRL_RST, o_count=0 same cycle, without a clock edge.
REQ-035 Streaming: 8 beats data=1..8, i_out_ready=1 always -> outputs 1..8 in order, each 1 cycle after acceptance, no bubbles.
REQ-036 Backpressure: i_out_ready=0 for 3 cycles with input valid -> no skid: o_in_ready=0, beat held stable; skid: second beat absorbed, o_count=2, o_in_ready=0.
REQ-037 Flush: i_flush with i_in_valid=1, data=0xA5 -> next cycle o_out_valid=0, o_out_ctrl=CTRL_RST; 0xA5 never appears at output.
REQ-038 Stall: i_stall=1 with FULL and i_out_ready=1 -> beat drains, next cycle o_out_valid=0 (bubble), o_out_ctrl=CTRL_RST.
REQ-039 Random valid/ready/stall for 10000 cycles, both macro settings -> scoreboard: order preserved, no loss outside flush.
